// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply-divide unit: opcodes, divider FSM states, and the divide-op decode.
package hilo_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MTHI  = 4'd1,
        MTLO  = 4'd2,
        MULT  = 4'd3,
        MULTU = 4'd4,
        DIV   = 4'd5,
        DIVU  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } hilo_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    function automatic logic is_div(input hilo_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// EX-stage request/response bundle for hilo_mdu; master is the pipeline, slave is the unit.
interface hilo_mdu_if #(parameter int DATA_W = 32);

    logic                  op_valid;
    hilo_pkg::hilo_op_e    op;
    logic [DATA_W-1:0]     src_a;
    logic [DATA_W-1:0]     src_b;
    logic                  flush;
    logic                  stall_o;
    logic                  busy_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  stall_o, busy_o, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output stall_o, busy_o, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_div_iter.sv
// Restoring divider datapath: loads magnitudes on i_start, one quotient bit per i_step, sign fix on outputs.
// Outputs are combinational from state; o_last flags the final iteration.
module hilo_div_iter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_last,
    output logic [DATA_W-1:0] o_quot,
    output logic [DATA_W-1:0] o_rem
);

    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_div;
    logic [DATA_W-1:0] r_raw_a;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;

    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;

    assign w_abs_a = (i_signed && i_a[DATA_W-1]) ? -i_a : i_a;
    assign w_abs_b = (i_signed && i_b[DATA_W-1]) ? -i_b : i_b;

    // A borrow out of the top bit means the trial subtract went negative: restore.
    assign w_shift = {r_rem, r_quot[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_quot  <= '0;
            r_div   <= '0;
            r_raw_a <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else if (i_start) begin
            r_rem   <= '0;
            r_quot  <= w_abs_a;
            r_div   <= w_abs_b;
            r_raw_a <= i_a;
            r_cnt   <= '0;
            r_neg_q <= i_signed & (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
            r_neg_r <= i_signed & i_a[DATA_W-1];
            r_dz    <= (i_b == '0);
        end else if (i_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (!w_diff[DATA_W]) begin
                r_rem  <= w_diff[DATA_W-1:0];
                r_quot <= {r_quot[DATA_W-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[DATA_W-1:0];
                r_quot <= {r_quot[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign o_last = (r_cnt == CNT_W'(DATA_W - 1));
    // min/-1 needs no special case: |min| divides to min, and the sign flags cancel.
    assign o_quot = r_dz ? '1      : (r_neg_q ? -r_quot : r_quot);
    assign o_rem  = r_dz ? r_raw_a : (r_neg_r ? -r_rem  : r_rem);

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO unit: moves and multiplies write at the accept edge; divides stall IF..EX for DATA_W+1 cycles, results land on the FIX edge.
// Optional multiply-accumulate (MADD/MADDU/MSUB/MSUBU) is built only when HILO_MADD_EN is defined.
module hilo_mdu
    import hilo_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic       clk,
    input  logic       rst,
    hilo_mdu_if.slave  bus
);

    div_state_e          r_state;
    div_state_e          w_next_state;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_accept;
    logic                w_div_start;
    logic                w_step;
    logic                w_stall;
    logic                w_last;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    logic                w_mul_signed;
    logic [2*DATA_W-1:0] w_ext_a;
    logic [2*DATA_W-1:0] w_ext_b;
    logic [2*DATA_W-1:0] w_prod;

    assign w_accept    = bus.op_valid && (r_state == IDLE) && !bus.flush;
    assign w_div_start = w_accept && is_div(bus.op);

    always_comb begin
        w_mul_signed = 1'b0;
        case (bus.op)
            MULT, MADD, MSUB: w_mul_signed = 1'b1;
            default:          w_mul_signed = 1'b0;
        endcase
    end

    // Truncated 2W x 2W product of extended operands equals the exact signed/unsigned product.
    assign w_ext_a = w_mul_signed ? {{DATA_W{bus.src_a[DATA_W-1]}}, bus.src_a} : {{DATA_W{1'b0}}, bus.src_a};
    assign w_ext_b = w_mul_signed ? {{DATA_W{bus.src_b[DATA_W-1]}}, bus.src_b} : {{DATA_W{1'b0}}, bus.src_b};
    assign w_prod  = w_ext_a * w_ext_b;

    hilo_div_iter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_div_start),
        .i_step   (w_step),
        .i_signed (bus.op == DIV),
        .i_a      (bus.src_a),
        .i_b      (bus.src_b),
        .o_last   (w_last),
        .o_quot   (w_quot),
        .o_rem    (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_div_start) w_next_state = RUN;
                RUN:     if (w_last)      w_next_state = FIX;
                FIX:     w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Stall drops in FIX so the held divide retires on the same edge HI/LO are written.
    always_comb begin
        w_step  = (r_state == RUN);
        w_stall = w_div_start || ((r_state == RUN) && !bus.flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept) begin
            case (bus.op)
                MTHI:        r_hi <= bus.src_a;
                MTLO:        r_lo <= bus.src_a;
                MULT, MULTU: {r_hi, r_lo} <= w_prod;
`ifdef HILO_MADD_EN
                MADD, MADDU: {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
                MSUB, MSUBU: {r_hi, r_lo} <= {r_hi, r_lo} - w_prod;
`endif
                default: ;
            endcase
        end else if ((r_state == FIX) && !bus.flush) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
        end
    end

    assign bus.stall_o = w_stall;
    assign bus.busy_o  = (r_state != IDLE);
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

endmodule
